alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/macro_pkg.sv | 6 +
 rtl/alu_rr_picker.sv | 29 ++
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/macro_pkg.sv
// macro_pkg: shared opcode, arbiter state and default sizing for the ALU arbiter slice
package macro_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR} opcode_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  localparam int ARB_NUM_REQ_DEFAULT = 4;
endpackage

// File: rtl/alu_rr_picker.sv
// alu_rr_picker: combinational round-robin pick of the first request at or after rr_ptr
module alu_rr_picker
  import macro_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEFAULT,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_req
);
  function automatic logic [IW-1:0] wrap(int i);
    return IW'(i >= NUM_REQ ? i - NUM_REQ : i);
  endfunction
  // Scan from the farthest candidate back so the nearest one wins.
  always_comb begin
    grant_idx = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap(int'(rr_ptr) + i)]) begin
        grant_idx = wrap(int'(rr_ptr) + i);
        any_req = 1'b1;
      end
    end
  end
  assign grant = any_req ? NUM_REQ'(1) << grant_idx : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NUM_REQ requesters, one op in flight.
// Define ALU_ARB_TIMEOUT_EN to bound the wait for alu_valid_out by TIMEOUT_CYCLES.
module alu_arbiter
  import macro_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][3:0] req_a,
  input  logic [NUM_REQ-1:0][3:0] req_b,
  input  logic [NUM_REQ-1:0]      req_cin,
  input  opcode_e [NUM_REQ-1:0]   req_ctl,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [3:0]              rsp_alu,
  output logic                    rsp_carry,
  output logic                    rsp_zero,
  output logic                    rsp_err,
  output logic                    alu_valid_in,
  output logic                    alu_cin,
  output logic [3:0]              alu_a,
  output logic [3:0]              alu_b,
  output opcode_e                 alu_ctl,
  input  logic                    alu_valid_out,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  input  logic [3:0]              alu_result
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("alu_arbiter: parameter out of range");
  end
  arb_state_e state, state_nx;
  logic [IW-1:0] rr_ptr, gnt_idx, pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic any_req, busy, resp, timeout, done;
  logic [3:0] a_q, b_q, res_q;
  logic cin_q, carry_q, zero_q, err_q;
  opcode_e ctl_q;
  alu_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .grant(pick),
    .grant_idx(pick_idx),
    .any_req(any_req)
  );
`ifdef ALU_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  always_ff @(posedge clk)
    tmo_cnt <= (reset || state != WAIT || alu_valid_out) ? '0 : tmo_cnt + 8'd1;
  assign timeout = state == WAIT && tmo_cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  assign done = state == WAIT && (alu_valid_out || timeout);
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_req ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = done ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      gnt_idx <= '0;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      ctl_q <= opcode_e'('0);
      res_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_idx <= pick_idx;
        a_q <= req_a[pick_idx];
        b_q <= req_b[pick_idx];
        cin_q <= req_cin[pick_idx];
        ctl_q <= req_ctl[pick_idx];
      end
      // A real result always beats a coincident timeout.
      if (done) begin
        res_q <= alu_valid_out ? alu_result : '0;
        carry_q <= alu_valid_out & alu_carry;
        zero_q <= alu_valid_out & alu_zero;
        err_q <= !alu_valid_out;
      end
      if (resp) rr_ptr <= gnt_idx == IW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
  assign busy = state == ISSUE || state == WAIT;
  assign resp = state == RESP;
  assign req_ready = (state == IDLE && !reset) ? pick : '0;
  assign alu_valid_in = state == ISSUE;
  assign alu_a = busy ? a_q : '0;
  assign alu_b = busy ? b_q : '0;
  assign alu_cin = busy & cin_q;
  assign alu_ctl = busy ? ctl_q : opcode_e'('0);
  assign rsp_valid = resp ? NUM_REQ'(1) << gnt_idx : '0;
  assign rsp_alu = resp ? res_q : '0;
  assign rsp_carry = resp & carry_q;
  assign rsp_zero = resp & zero_q;
  assign rsp_err = resp & err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  import macro_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid, req_ready, req_cin, rsp_valid;
  logic [N-1:0][3:0] req_a, req_b;
  opcode_e [N-1:0] req_ctl;
  logic [3:0] rsp_alu, alu_a, alu_b, alu_result;
  logic rsp_carry, rsp_zero, rsp_err, alu_valid_in, alu_cin;
  logic alu_valid_out, alu_carry, alu_zero;
  opcode_e alu_ctl;
  int n_chk = 0, n_fail = 0, rr = 0;

  alu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ctl(req_ctl),
    .rsp_valid(rsp_valid), .rsp_alu(rsp_alu), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .alu_valid_in(alu_valid_in),
    .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_valid_out(alu_valid_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string t);
    chk({t, "_req_ready"}, 32'(req_ready), 0);
    chk({t, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({t, "_rsp_bus"}, {25'd0, rsp_alu, rsp_carry, rsp_zero, rsp_err}, 0);
    chk({t, "_alu_drive"}, {20'd0, alu_valid_in, alu_cin, alu_a, alu_b, 32'(alu_ctl) == 0 ? 2'b00 : 2'b11}, 0);
  endtask

  function automatic int pick_model(input logic [N-1:0] rv);
    for (int i = 0; i < N; i++) if (rv[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic c, input opcode_e op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b} + 5'(c);
      OP_SUB:  return {1'b0, a} - {1'b0, b} - 5'(c);
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOT:  return {1'b0, ~a};
      OP_SHL:  return {a, 1'b0};
      default: return {a[0], 1'b0, a[3:1]};
    endcase
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 4'($urandom);
      req_b[i] = 4'($urandom);
      req_cin[i] = 1'($urandom);
      req_ctl[i] = opcode_e'(3'($urandom_range(0, 7)));
    end
  endtask

  // Starts in an IDLE cycle (at a negedge) and returns in the following IDLE cycle.
  task automatic do_op(input logic [N-1:0] rv, input int lat, input int exp_g);
    int g;
    logic [4:0] r;
    g = pick_model(rv);
    req_valid = rv;
    #1;
    chk("grant", 32'(req_ready), 32'(1) << g);
    if (exp_g >= 0) chk("directed_grant", 32'(req_ready), 32'(1) << exp_g);
    @(negedge clk);
    chk("issue_valid_in", 32'(alu_valid_in), 1);
    chk("issue_ops", {19'd0, alu_a, alu_b, alu_cin, alu_ctl}, {19'd0, req_a[g], req_b[g], req_cin[g], req_ctl[g]});
    chk("issue_no_ready", 32'(req_ready), 0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait_hold", {18'd0, alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl}, {18'd0, 1'b0, req_a[g], req_b[g], req_cin[g], req_ctl[g]});
      chk("wait_no_rsp", 32'(rsp_valid), 0);
    end
    @(negedge clk);
    r = alu_fn(req_a[g], req_b[g], req_cin[g], req_ctl[g]);
    alu_valid_out = 1'b1;
    alu_result = r[3:0];
    alu_carry = r[4];
    alu_zero = r[3:0] == 4'd0;
    @(negedge clk);
    alu_valid_out = 1'b0;
    alu_result = ~r[3:0];
    alu_carry = ~r[4];
    alu_zero = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 32'(1) << g);
    chk("rsp_bus", {25'd0, rsp_alu, rsp_carry, rsp_zero, rsp_err}, {25'd0, r[3:0], r[4], r[3:0] == 4'd0, 1'b0});
    chk("resp_no_ready", 32'(req_ready), 0);
    rr = (g + 1) % N;
    req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    int g, seen;
    req_valid = '0;
    rand_ops();
    alu_valid_out = 1'b0;
    alu_result = '0;
    alu_carry = 1'b0;
    alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    // Fairness with all four requesting continuously.
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      do_op(4'b1111, k % 3, k % 4);
    end
    // Single 3+4 addition.
    req_a[0] = 4'h3;
    req_b[0] = 4'h4;
    req_cin[0] = 1'b0;
    req_ctl[0] = OP_ADD;
    do_op(4'b0001, 0, 0);
    chk("add_result_visible_once", 32'(rsp_valid), 0);
    // Wrap and skip: move pointer to 3, then 0101 grants 0 then 2.
    do_op(4'b0100, 1, 2);
    rand_ops();
    do_op(4'b0101, 0, 0);
    rand_ops();
    do_op(4'b0101, 2, 2);
    // A request withdrawn before the edge is not granted.
    req_valid = 4'b0010;
    #1;
    req_valid = '0;
    #1;
    chk("drop_no_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("drop_no_issue", 32'(alu_valid_in), 0);
    // Stray ALU response while idle.
    alu_valid_out = 1'b1;
    alu_result = 4'hf;
    repeat (2) begin
      @(negedge clk);
      chk("stray_no_rsp", 32'(rsp_valid), 0);
      chk("stray_no_issue", 32'(alu_valid_in), 0);
    end
    alu_valid_out = 1'b0;
    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      rand_ops();
      do_op(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 5)), -1);
    end
    // Result arriving on the last permitted wait cycle is still a real result.
    rand_ops();
    do_op(4'b1001, 14, -1);
    // Reset while waiting on the ALU.
    rand_ops();
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("rst_wait");
    reset = 1'b0;
    rr = 0;
    alu_valid_out = 1'b1;
    @(negedge clk);
    chk("rst_wait_no_rsp", 32'(rsp_valid), 0);
    alu_valid_out = 1'b0;
    @(negedge clk);
    chk("rst_wait_no_rsp2", 32'(rsp_valid), 0);
    rand_ops();
    do_op(4'b0010, 0, 1);
    // ALU that never answers.
    rand_ops();
    g = pick_model(4'b1000);
    req_valid = 4'b1000;
    #1;
    chk("tmo_grant", 32'(req_ready), 32'(1) << g);
    @(negedge clk);
    req_valid = '0;
    seen = 0;
`ifdef ALU_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    chk("tmo_no_early_rsp", seen, 0);
    @(negedge clk);
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'(1) << g);
    chk("tmo_rsp_bus", {25'd0, rsp_alu, rsp_carry, rsp_zero, rsp_err}, 1);
    rr = (g + 1) % N;
    @(negedge clk);
    chk("tmo_single_pulse", 32'(rsp_valid), 0);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    chk("no_tmo_rsp", seen, 0);
    chk("no_tmo_holds", {27'd0, alu_a, alu_valid_in}, {27'd0, req_a[g], 1'b0});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rr = 0;
`endif
    rand_ops();
    do_op(4'b1111, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
